// File: rtl/dendrite_arbiter.sv
// rtl/dendrite_arbiter.sv - round-robin synapse / priority incoming arbiter feeding a 2-entry dendrite skid buffer
module dendrite_arbiter #(
  parameter int NUM_SYN    = 4,
  parameter int ADDR_W     = 8,
  parameter int CHARGE_W   = 8,
  parameter int STARVE_MAX = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [NUM_SYN*ADDR_W-1:0]    syn_addr,
  input  logic [NUM_SYN*CHARGE_W-1:0]  syn_charge,
  input  logic [NUM_SYN-1:0]           syn_vld,
  output logic [NUM_SYN-1:0]           syn_rdy,
  input  logic [ADDR_W-1:0]            incoming_addr,
  input  logic [CHARGE_W-1:0]          incoming_charge,
  input  logic                         incoming_vld,
  output logic                         incoming_rdy,
  output logic [ADDR_W-1:0]            dend_addr,
  output logic [CHARGE_W:0]            dend_charge,
  output logic                         dend_vld,
  input  logic                         dend_rdy
);

  localparam int PW = (NUM_SYN > 1) ? $clog2(NUM_SYN) : 1;
  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam int DW = ADDR_W + CHARGE_W + 1;
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [PW-1:0] LAST_PORT  = PW'(NUM_SYN - 1);

  logic [1:0]    count;
  logic [PW-1:0] rr_ptr;
  logic [SW-1:0] starve_cnt;
  logic [DW-1:0] buf_q [2];
  logic          rd_idx;
  logic          wr_idx;

  logic          can_grant;
  logic          any_syn;
  logic          starved;
  logic          grant_in;
  logic          grant_syn;
  logic          syn_found;
  logic [PW-1:0] syn_sel;
  int            scan_idx;
  logic          push;
  logic          pop;
  logic [ADDR_W-1:0]   syn_addr_sel;
  logic [CHARGE_W-1:0] syn_charge_sel;
  logic [DW-1:0]       push_data;

  // Grants depend only on registered occupancy, never on dend_rdy.
  assign can_grant = enable && (count < 2'd2) && !reset;
  assign any_syn   = |syn_vld;
  assign starved   = (STARVE_MAX != 0) && (starve_cnt == STARVE_LIM) && any_syn;
  assign grant_in  = can_grant && incoming_vld && !starved;
  assign grant_syn = can_grant && !grant_in && syn_found;

  always_comb begin
    syn_found = 1'b0;
    syn_sel   = '0;
    scan_idx  = 0;
    for (int i = 0; i < NUM_SYN; i++) begin
      scan_idx = (int'(rr_ptr) + i) % NUM_SYN;
      if (!syn_found && syn_vld[scan_idx]) begin
        syn_found = 1'b1;
        syn_sel   = PW'(scan_idx);
      end
    end
  end

  always_comb begin
    syn_rdy = '0;
    if (grant_syn) syn_rdy[syn_sel] = 1'b1;
  end

  assign incoming_rdy = grant_in;

  assign syn_addr_sel   = syn_addr[syn_sel*ADDR_W +: ADDR_W];
  assign syn_charge_sel = syn_charge[syn_sel*CHARGE_W +: CHARGE_W];

  // Synapse charge is signed, incoming charge unsigned.
  assign push_data = grant_in ? {incoming_addr, 1'b0, incoming_charge}
                              : {syn_addr_sel, syn_charge_sel[CHARGE_W-1], syn_charge_sel};

  assign push = grant_in || grant_syn;
  assign pop  = (count != 2'd0) && dend_rdy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= 2'd0;
      rd_idx   <= 1'b0;
      wr_idx   <= 1'b0;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
    end else begin
      if (push) begin
        buf_q[wr_idx] <= push_data;
        wr_idx        <= ~wr_idx;
      end
      if (pop) rd_idx <= ~rd_idx;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign dend_vld                 = (count != 2'd0);
  assign {dend_addr, dend_charge} = buf_q[rd_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr     <= '0;
      starve_cnt <= '0;
    end else if (enable) begin
      if (grant_syn) rr_ptr <= (syn_sel == LAST_PORT) ? '0 : syn_sel + 1'b1;
      if (grant_syn || !any_syn) starve_cnt <= '0;
      else if (grant_in && starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_dendrite_arbiter.sv
// tb/tb_dendrite_arbiter.sv - queue-model bench for dendrite_arbiter with directed scenarios
module tb_dendrite_arbiter;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int CW = 8;
  localparam int SM = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            enable = 1'b1;
  logic [N*AW-1:0] syn_addr = '0;
  logic [N*CW-1:0] syn_charge = '0;
  logic [N-1:0]    syn_vld = '0;
  logic [N-1:0]    syn_rdy;
  logic [AW-1:0]   incoming_addr = '0;
  logic [CW-1:0]   incoming_charge = '0;
  logic            incoming_vld = 1'b0;
  logic            incoming_rdy;
  logic [AW-1:0]   dend_addr;
  logic [CW:0]     dend_charge;
  logic            dend_vld;
  logic            dend_rdy = 1'b0;

  dendrite_arbiter #(.NUM_SYN(N), .ADDR_W(AW), .CHARGE_W(CW), .STARVE_MAX(SM)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .syn_addr(syn_addr), .syn_charge(syn_charge), .syn_vld(syn_vld), .syn_rdy(syn_rdy),
    .incoming_addr(incoming_addr), .incoming_charge(incoming_charge),
    .incoming_vld(incoming_vld), .incoming_rdy(incoming_rdy),
    .dend_addr(dend_addr), .dend_charge(dend_charge), .dend_vld(dend_vld), .dend_rdy(dend_rdy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_syn(input int k, input logic [AW-1:0] a, input logic [CW-1:0] c);
    syn_addr[k*AW +: AW]   = a;
    syn_charge[k*CW +: CW] = c;
  endtask

  function automatic int gcode();
    if (incoming_rdy) return 4;
    for (int k = 0; k < N; k++)
      if (syn_rdy[k]) return k;
    return -1;
  endfunction

  // Reference model: an expected-output queue plus pointer and starvation count.
  typedef struct { int a; int c; } fire_t;
  fire_t mq[$];
  int    m_rr = 0;
  int    m_sc = 0;
  int    m_gin;
  int    m_gs;
  int    m_v;
  bit    m_any;
  bit    m_can;
  bit    m_starved;

  always @(negedge clk) begin
    if (reset) begin
      mq.delete();
      m_rr = 0;
      m_sc = 0;
      chk("rst_dend_vld", int'(dend_vld), 0);
      chk("rst_syn_rdy", int'(syn_rdy), 0);
      chk("rst_in_rdy", int'(incoming_rdy), 0);
    end else begin
      m_any     = (syn_vld != 0);
      m_can     = enable && (mq.size() < 2);
      m_starved = (SM != 0) && (m_sc == SM) && m_any;
      m_gin     = int'(m_can && incoming_vld && !m_starved);
      m_gs      = -1;
      if (m_can && m_gin == 0)
        for (int i = 0; i < N; i++)
          if (m_gs < 0 && syn_vld[(m_rr + i) % N]) m_gs = (m_rr + i) % N;
      chk("syn_rdy", int'(syn_rdy), (m_gs >= 0) ? (1 << m_gs) : 0);
      chk("in_rdy", int'(incoming_rdy), m_gin);
      chk("dend_vld", int'(dend_vld), int'(mq.size() > 0));
      if (mq.size() > 0) begin
        chk("dend_addr", int'(dend_addr), mq[0].a);
        chk("dend_charge", int'(dend_charge), mq[0].c);
      end
      if (mq.size() > 0 && dend_rdy) void'(mq.pop_front());
      if (m_gin != 0) begin
        mq.push_back('{a: int'(incoming_addr), c: int'(incoming_charge)});
      end else if (m_gs >= 0) begin
        m_v = int'($signed(syn_charge[m_gs*CW +: CW]));
        mq.push_back('{a: int'(syn_addr[m_gs*AW +: AW]), c: m_v & 32'h1FF});
      end
      if (enable) begin
        if (m_gs >= 0) begin
          m_rr = (m_gs + 1) % N;
          m_sc = 0;
        end else if (!m_any) begin
          m_sc = 0;
        end else if (m_gin != 0 && m_sc < SM) begin
          m_sc++;
        end
      end
    end
  end

  int g[6];

  initial begin
    // reset state, with requests pending
    syn_vld = 4'hF;
    incoming_vld = 1'b1;
    step();
    chk("init_dend_vld", int'(dend_vld), 0);
    chk("init_dend_addr", int'(dend_addr), 0);
    chk("init_dend_charge", int'(dend_charge), 0);
    chk("init_syn_rdy", int'(syn_rdy), 0);
    chk("init_in_rdy", int'(incoming_rdy), 0);
    syn_vld = '0;
    incoming_vld = 1'b0;
    reset = 1'b0;
    step();

    // backpressure and sign extension
    dend_rdy = 1'b0;
    set_syn(0, 8'h11, 8'h80);
    syn_vld = 4'b0001;
    @(negedge clk);
    chk("bp_grant1", gcode(), 0);
    step();
    chk("bp_latency", int'(dend_vld), 1);
    chk("bp_head_neg", int'(dend_charge), 'h180);
    set_syn(0, 8'h12, 8'h7F);
    @(negedge clk);
    chk("bp_grant2", gcode(), 0);
    step();
    @(negedge clk);
    chk("bp_full_no_grant", int'(syn_rdy), 0);
    step();
    dend_rdy = 1'b1;
    set_syn(0, 8'h13, 8'h05);
    chk("bp_head_hold", int'(dend_charge), 'h180);
    chk("bp_head_addr", int'(dend_addr), 'h11);
    @(negedge clk);
    chk("bp_full_pop_no_grant", int'(syn_rdy), 0);
    step();
    chk("bp_second_pos", int'(dend_charge), 'h07F);
    @(negedge clk);
    chk("bp_grant_resume", int'(syn_rdy), 1);
    step();
    syn_vld = '0;
    chk("bp_third", int'(dend_charge), 'h005);
    step();
    chk("bp_drained", int'(dend_vld), 0);

    // reset with two entries buffered
    dend_rdy = 1'b0;
    set_syn(1, 8'h21, 8'h01);
    syn_vld = 4'b0010;
    step();
    step();
    chk("pre_reset_vld", int'(dend_vld), 1);
    incoming_vld = 1'b1;
    reset = 1'b1;
    #1;
    chk("async_rst_vld", int'(dend_vld), 0);
    chk("async_rst_syn_rdy", int'(syn_rdy), 0);
    chk("async_rst_in_rdy", int'(incoming_rdy), 0);
    syn_vld = '0;
    incoming_vld = 1'b0;
    step();
    reset = 1'b0;
    chk("post_rst_vld", int'(dend_vld), 0);
    step();
    chk("post_rst_vld2", int'(dend_vld), 0);

    // round robin from rr_ptr = 0
    for (int k = 0; k < N; k++) set_syn(k, 8'(8'h20 + k), 8'(k + 1));
    syn_vld = 4'hF;
    dend_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      g[i] = gcode();
      if (i == 0) chk("rr_vld_before", int'(dend_vld), 0);
      if (i == 1) chk("rr_vld_after", int'(dend_vld), 1);
      step();
    end
    chk("rr_g0", g[0], 0);
    chk("rr_g1", g[1], 1);
    chk("rr_g2", g[2], 2);
    chk("rr_g3", g[3], 3);
    chk("rr_g4", g[4], 0);
    syn_vld = '0;
    step();
    step();

    // starvation limit 2
    incoming_addr = 8'h40;
    incoming_charge = 8'h10;
    incoming_vld = 1'b1;
    syn_vld = 4'b0100;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      g[i] = gcode();
      step();
    end
    chk("sv_g0", g[0], 4);
    chk("sv_g1", g[1], 4);
    chk("sv_g2", g[2], 2);
    chk("sv_g3", g[3], 4);
    chk("sv_g4", g[4], 4);
    chk("sv_g5", g[5], 2);
    incoming_vld = 1'b0;
    syn_vld = '0;
    step();
    step();

    // incoming zero extension
    incoming_addr = 8'h3A;
    incoming_charge = 8'hFF;
    incoming_vld = 1'b1;
    step();
    incoming_vld = 1'b0;
    chk("in_ext_vld", int'(dend_vld), 1);
    chk("in_ext_addr", int'(dend_addr), 'h3A);
    chk("in_ext_charge", int'(dend_charge), 'h0FF);
    step();

    // enable low: drain, no grants, pointer held (rr_ptr = 1 after port 0)
    dend_rdy = 1'b0;
    set_syn(0, 8'h50, 8'hFE);
    syn_vld = 4'b0001;
    step();
    enable = 1'b0;
    syn_vld = 4'hF;
    dend_rdy = 1'b1;
    chk("en_buffered", int'(dend_vld), 1);
    @(negedge clk);
    chk("en_no_grant1", int'(syn_rdy), 0);
    step();
    chk("en_drained", int'(dend_vld), 0);
    @(negedge clk);
    chk("en_no_grant2", int'(syn_rdy), 0);
    step();
    enable = 1'b1;
    @(negedge clk);
    chk("en_rr_hold", gcode(), 1);
    step();
    syn_vld = '0;
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
